// File: rtl/fetch_sequencer.sv
// -----------------------------------------------------------------------------
// fetch_sequencer
//   Owns the fetch PC and issues one instruction-memory read at a time over a
//   req/ready handshake. Fetched words go to ID through an output register
//   backed by a single skid entry. Exception redirects beat branch redirects,
//   and a redirect that lands while a read is in flight turns that read's
//   response stale, so it is dropped.
//
// Ports
//   clk_i                 clock, all state updates on the rising edge
//   rst_ni                synchronous active-low reset
//   stall_i               ID cannot accept an instruction this cycle
//   redirect_exc_i/exc_pc_i  exception redirect request and target
//   redirect_br_i/br_pc_i    branch redirect request and target
//   mem_req_o/mem_addr_o     read request and address (stable until ready)
//   mem_ready_i/mem_rdata_i  read completion and instruction word
//   instr1_o              instruction to ID
//   instr_pc_o            address of instr1_o
//   instr_pc_plus4_o      instr_pc_o + PC_INCR
//   instr1_available_o    instr1_o holds a valid instruction
//   wait_cycles_o         saturating count of request cycles without ready
// -----------------------------------------------------------------------------
module fetch_sequencer #(
  parameter logic [31:0] RESET_PC = 32'hBFC00000,
  parameter logic [31:0] PC_INCR  = 32'd4,
  parameter int          WCNT_W   = 16
) (
  input  logic              clk_i,
  input  logic              rst_ni,
  input  logic              stall_i,
  input  logic              redirect_exc_i,
  input  logic [31:0]       exc_pc_i,
  input  logic              redirect_br_i,
  input  logic [31:0]       br_pc_i,
  output logic              mem_req_o,
  output logic [31:0]       mem_addr_o,
  input  logic              mem_ready_i,
  input  logic [31:0]       mem_rdata_i,
  output logic [31:0]       instr1_o,
  output logic [31:0]       instr_pc_o,
  output logic [31:0]       instr_pc_plus4_o,
  output logic              instr1_available_o,
  output logic [WCNT_W-1:0] wait_cycles_o
);

  typedef enum logic [1:0] {
    S_FETCH  = 2'd0,
    S_SQUASH = 2'd1,
    S_HOLD   = 2'd2
  } state_e;

  state_e            state_q;
  logic [31:0]       pc_q;
  logic [31:0]       pend_q;
  logic [31:0]       instr_q;
  logic [31:0]       ipc_q;
  logic [31:0]       iplus4_q;
  logic              avail_q;
  logic [31:0]       skid_instr_q;
  logic [31:0]       skid_pc_q;
  logic [WCNT_W-1:0] wait_q;

  logic        redir;
  logic [31:0] target;
  logic        consume;
  logic        slot_free;

  assign redir     = redirect_exc_i | redirect_br_i;
  assign target    = redirect_exc_i ? exc_pc_i : br_pc_i;
  assign consume   = avail_q & ~stall_i;
  assign slot_free = ~avail_q | consume;

  // While a redirect is pending in SQUASH, pc_q still holds the stale address
  // so the request address never moves under an outstanding read.
  assign mem_req_o          = (state_q != S_HOLD);
  assign mem_addr_o         = pc_q;
  assign instr1_o           = instr_q;
  assign instr_pc_o         = ipc_q;
  assign instr_pc_plus4_o   = iplus4_q;
  assign instr1_available_o = avail_q;
  assign wait_cycles_o      = wait_q;

  always_ff @(posedge clk_i) begin
    if (!rst_ni) begin
      state_q      <= S_FETCH;
      pc_q         <= RESET_PC;
      pend_q       <= '0;
      instr_q      <= '0;
      ipc_q        <= '0;
      iplus4_q     <= '0;
      avail_q      <= 1'b0;
      skid_instr_q <= '0;
      skid_pc_q    <= '0;
      wait_q       <= '0;
    end else begin
      if (mem_req_o && !mem_ready_i && !(&wait_q)) begin
        wait_q <= wait_q + WCNT_W'(1);
      end

      // A consumed word leaves the output register unless something below
      // reloads it in the same cycle.
      if (consume) begin
        avail_q <= 1'b0;
      end

      unique case (state_q)
        S_FETCH: begin
          if (mem_ready_i) begin
            if (redir) begin
              pc_q    <= target;
              avail_q <= 1'b0;
            end else if (slot_free) begin
              instr_q  <= mem_rdata_i;
              ipc_q    <= pc_q;
              iplus4_q <= pc_q + PC_INCR;
              avail_q  <= 1'b1;
              pc_q     <= pc_q + PC_INCR;
            end else begin
              skid_instr_q <= mem_rdata_i;
              skid_pc_q    <= pc_q;
              pc_q         <= pc_q + PC_INCR;
              state_q      <= S_HOLD;
            end
          end else if (redir) begin
            pend_q  <= target;
            avail_q <= 1'b0;
            state_q <= S_SQUASH;
          end
        end

        S_SQUASH: begin
          avail_q <= 1'b0;
          if (mem_ready_i) begin
            // The newest redirect wins over the one already pending.
            pc_q    <= redir ? target : pend_q;
            state_q <= S_FETCH;
          end else if (redir) begin
            pend_q <= target;
          end
        end

        S_HOLD: begin
          if (redir) begin
            avail_q <= 1'b0;
            pc_q    <= target;
            state_q <= S_FETCH;
          end else if (consume) begin
            instr_q  <= skid_instr_q;
            ipc_q    <= skid_pc_q;
            iplus4_q <= skid_pc_q + PC_INCR;
            avail_q  <= 1'b1;
            state_q  <= S_FETCH;
          end
        end

        default: begin
          state_q <= S_FETCH;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_fetch_sequencer.sv
// -----------------------------------------------------------------------------
// tb_fetch_sequencer
//   Transaction-level model: the words that ID will see form an ordered queue.
//   A response that is not stale and arrives with no redirect appends its
//   word. A redirect drops every word not yet consumed. A request is
//   outstanding whenever fewer than two words are buffered. The monitor pops
//   the queue on every consume that the DUT shows and compares the word.
// -----------------------------------------------------------------------------
module tb_fetch_sequencer;

  localparam logic [31:0] RESET_PC = 32'hBFC00000;

  typedef struct packed {
    logic [31:0] instr;
    logic [31:0] pc;
  } item_t;

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic        stall = 1'b0;
  logic        redirect_exc = 1'b0;
  logic [31:0] exc_pc = '0;
  logic        redirect_br = 1'b0;
  logic [31:0] br_pc = '0;
  logic        mem_req;
  logic [31:0] mem_addr;
  logic        mem_ready = 1'b0;
  logic [31:0] mem_rdata;
  logic [31:0] instr1;
  logic [31:0] instr_pc;
  logic [31:0] instr_pc_plus4;
  logic        instr1_available;
  logic [15:0] wait_cycles;

  always #5 clk = ~clk;

  fetch_sequencer #(
    .RESET_PC(RESET_PC),
    .PC_INCR (32'd4),
    .WCNT_W  (16)
  ) dut (
    .clk_i             (clk),
    .rst_ni            (rst_n),
    .stall_i           (stall),
    .redirect_exc_i    (redirect_exc),
    .exc_pc_i          (exc_pc),
    .redirect_br_i     (redirect_br),
    .br_pc_i           (br_pc),
    .mem_req_o         (mem_req),
    .mem_addr_o        (mem_addr),
    .mem_ready_i       (mem_ready),
    .mem_rdata_i       (mem_rdata),
    .instr1_o          (instr1),
    .instr_pc_o        (instr_pc),
    .instr_pc_plus4_o  (instr_pc_plus4),
    .instr1_available_o(instr1_available),
    .wait_cycles_o     (wait_cycles)
  );

  // Instruction memory content is a fixed function of the address; the bus
  // carries a different value when no response is given.
  function automatic logic [31:0] mem_word(input logic [31:0] a);
    return {a[15:0], a[31:16]} ^ 32'hA5C3_1E0F;
  endfunction

  assign mem_rdata = mem_ready ? mem_word(mem_addr) : ~mem_word(mem_addr);

  // Reference model state
  item_t       sb_q[$];
  logic [31:0] m_addr = RESET_PC;
  logic [31:0] m_pend = '0;
  bit          m_stale = 1'b0;
  logic [15:0] m_wait = '0;
  int          n_resets = 0;
  bit          mon_en = 1'b0;

  int n_chk = 0;
  int n_fail = 0;
  int n_reset_chk = 0;

  // One clock cycle of stimulus, then the model is advanced to the state the
  // DUT should hold after that edge.
  task automatic step(input bit rn, input bit st, input bit rdy,
                      input bit ex, input logic [31:0] epc,
                      input bit br, input logic [31:0] bpc);
    bit          req;
    bit          redir;
    bit          rdy_eff;
    logic [31:0] tgt;
    item_t       it;
    req     = (sb_q.size() < 2);
    rdy_eff = rdy & req & rn;
    redir   = ex | br;
    tgt     = ex ? epc : bpc;
    rst_n        = rn;
    stall        = st;
    mem_ready    = rdy_eff;
    redirect_exc = ex;
    exc_pc       = epc;
    redirect_br  = br;
    br_pc        = bpc;
    @(posedge clk);
    #1;
    if (!rn) begin
      sb_q.delete();
      m_addr  = RESET_PC;
      m_pend  = '0;
      m_stale = 1'b0;
      m_wait  = '0;
      n_resets++;
    end else begin
      if (req && !rdy_eff && m_wait != 16'hFFFF) m_wait++;
      if (redir) sb_q.delete();
      if (req && rdy_eff) begin
        if (redir) begin
          m_addr = tgt;
        end else if (m_stale) begin
          m_addr = m_pend;
        end else begin
          it.instr = mem_word(m_addr);
          it.pc    = m_addr;
          sb_q.push_back(it);
          m_addr = m_addr + 32'd4;
        end
        m_stale = 1'b0;
      end else if (req) begin
        if (redir) begin
          m_stale = 1'b1;
          m_pend  = tgt;
        end
      end else if (redir) begin
        m_addr = tgt;
      end
    end
  endtask

  task automatic run(input int n, input bit st, input bit rdy);
    for (int i = 0; i < n; i++) step(1'b1, st, rdy, 1'b0, '0, 1'b0, '0);
  endtask

  // Monitor / scoreboard checker
  always @(negedge clk) begin : monitor
    item_t exp_it;
    bit    exp_av;
    bit    exp_req;
    if (mon_en) begin
      exp_av  = (sb_q.size() != 0);
      exp_req = (sb_q.size() < 2);

      n_chk++;
      if (instr1_available !== exp_av) begin
        n_fail++;
        $display("FAIL avail: got %b, expected %b", instr1_available, exp_av);
      end
      n_chk++;
      if (mem_req !== exp_req) begin
        n_fail++;
        $display("FAIL mem_req: got %b, expected %b", mem_req, exp_req);
      end
      if (exp_req) begin
        n_chk++;
        if (mem_addr !== m_addr) begin
          n_fail++;
          $display("FAIL mem_addr: got %h, expected %h", mem_addr, m_addr);
        end
      end
      n_chk++;
      if (wait_cycles !== m_wait) begin
        n_fail++;
        $display("FAIL wait_cycles: got %0d, expected %0d", wait_cycles, m_wait);
      end

      if (n_reset_chk != n_resets) begin
        n_reset_chk = n_resets;
        n_chk++;
        if (instr1 !== '0 || instr_pc !== '0 || instr_pc_plus4 !== '0) begin
          n_fail++;
          $display("FAIL reset_outputs: got instr=%h pc=%h plus4=%h, expected all 0",
                   instr1, instr_pc, instr_pc_plus4);
        end
      end

      if (instr1_available === 1'b1 && stall === 1'b0) begin
        n_chk++;
        if (sb_q.size() == 0) begin
          n_fail++;
          $display("FAIL deliver: got pc=%h with scoreboard empty, expected no delivery", instr_pc);
        end else begin
          exp_it = sb_q.pop_front();
          if (instr1 !== exp_it.instr || instr_pc !== exp_it.pc ||
              instr_pc_plus4 !== exp_it.pc + 32'd4) begin
            n_fail++;
            $display("FAIL deliver: got instr=%h pc=%h plus4=%h, expected instr=%h pc=%h plus4=%h",
                     instr1, instr_pc, instr_pc_plus4,
                     exp_it.instr, exp_it.pc, exp_it.pc + 32'd4);
          end else begin
            $display("deliver pc=%h instr=%h ok", instr_pc, instr1);
          end
        end
      end
    end
  end

  initial begin
    // Reset, then back-to-back fetch with ready every cycle
    step(1'b0, 1'b0, 1'b0, 1'b0, '0, 1'b0, '0);
    mon_en = 1'b1;
    run(4, 1'b0, 1'b1);

    // Stall with memory ready: second word lands in the skid, then drains
    run(3, 1'b1, 1'b1);
    run(5, 1'b0, 1'b1);

    // Memory wait with a branch redirect arriving mid-wait
    step(1'b0, 1'b0, 1'b0, 1'b0, '0, 1'b0, '0);
    step(1'b1, 1'b0, 1'b0, 1'b0, '0, 1'b0, '0);
    step(1'b1, 1'b0, 1'b0, 1'b0, '0, 1'b1, 32'h0040_0100);
    run(2, 1'b0, 1'b0);
    run(4, 1'b0, 1'b1);

    // Simultaneous exception and branch redirect with a response
    step(1'b1, 1'b0, 1'b1, 1'b1, 32'h8000_0180, 1'b1, 32'h0040_0200);
    run(3, 1'b0, 1'b1);

    // Two redirects while squashing; the later exception target wins
    step(1'b1, 1'b0, 1'b0, 1'b0, '0, 1'b1, 32'h0040_0300);
    step(1'b1, 1'b0, 1'b0, 1'b1, 32'h8000_0180, 1'b0, '0);
    run(4, 1'b0, 1'b1);

    // Redirect together with a response, then PC wrap past FFFFFFFC
    step(1'b1, 1'b0, 1'b1, 1'b0, '0, 1'b1, 32'hFFFF_FFF8);
    run(5, 1'b0, 1'b1);

    // Reset while holding a word in the skid
    run(3, 1'b1, 1'b1);
    step(1'b0, 1'b1, 1'b1, 1'b0, '0, 1'b0, '0);
    run(4, 1'b0, 1'b1);

    // Randomized traffic
    for (int i = 0; i < 1500; i++) begin
      bit          rn;
      bit          st;
      bit          rdy;
      bit          ex;
      bit          br;
      logic [31:0] epc;
      logic [31:0] bpc;
      rn  = ($urandom_range(0, 199) != 0);
      st  = ($urandom_range(0, 2) == 0);
      rdy = ($urandom_range(0, 4) < 3);
      ex  = ($urandom_range(0, 39) == 0);
      br  = ($urandom_range(0, 19) == 0);
      epc = $urandom & 32'hFFFF_FFFC;
      bpc = ($urandom_range(0, 7) == 0) ? 32'hFFFF_FFF4 : ($urandom & 32'hFFFF_FFFC);
      step(rn, st, rdy, ex, epc, br, bpc);
    end

    run(6, 1'b0, 1'b1);
    @(negedge clk);
    #2;
    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end

endmodule
